// File: rtl/hazard_track_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_track_if
// Description : Bundle between the fetch/control side and the hazard
//               tracker.
//               Inputs to tracker : en, inst_in, flush
//               Outputs           : per-stage regWrt / wrtReg / branchInst
//                                   flags for D, X, M and W, plus the
//                                   bubble_cnt counter
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_track_if;
   logic        en;
   logic [15:0] inst_in;
   logic        flush;

   logic        regWrtD, regWrtX, regWrtM, regWrtW;
   logic [2:0]  wrtRegD, wrtRegX, wrtRegM, wrtRegW;
   logic        branchInstD, branchInstX, branchInstM, branchInstW;
   logic [15:0] bubble_cnt;

   // Tracker side
   modport slave (
      input  en, inst_in, flush,
      output regWrtD, regWrtX, regWrtM, regWrtW,
      output wrtRegD, wrtRegX, wrtRegM, wrtRegW,
      output branchInstD, branchInstX, branchInstM, branchInstW,
      output bubble_cnt
   );

   // Pipeline-control side
   modport master (
      output en, inst_in, flush,
      input  regWrtD, regWrtX, regWrtM, regWrtW,
      input  wrtRegD, wrtRegX, wrtRegM, wrtRegW,
      input  branchInstD, branchInstX, branchInstM, branchInstW,
      input  bubble_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_track.sv
`default_nettype none
// ============================================================================
// Module      : hazard_track
// Description : Tracks which pipeline stages (D, X, M, W) hold a
//               register-writing instruction, its destination register and
//               whether it is a control transfer. Also counts the NOP
//               bubbles entering D.
//               clk  : pipeline clock
//               rst  : synchronous active-high reset
//               bus  : hazard_track_if.slave (en, inst_in, flush in;
//                      per-stage flags and bubble_cnt out)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_track #(
   parameter logic [15:0] NOP = 16'h0800
) (
   input  wire logic     clk,
   input  wire logic     rst,
   hazard_track_if.slave bus
);

   localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

   // Stage entry layout: {regWrt, wrtReg[2:0], branch}
   logic [4:0]  r_stageD, r_stageX, r_stageM, r_stageW;
   logic [15:0] r_bubbleCnt;
   logic [4:0]  w_decoded;
   logic [4:0]  w_opcode;

   assign w_opcode = bus.inst_in[15:11];

   // Destination field position depends on the instruction format; the
   // destination is forced to zero whenever nothing is written.
   always_comb begin
      w_decoded = 5'b0;
      casez (w_opcode)
         5'b11011, 5'b11010, 5'b111??, 5'b11001:
            w_decoded = {1'b1, bus.inst_in[4:2], 1'b0};
         5'b010??, 5'b101??, 5'b10001:
            w_decoded = {1'b1, bus.inst_in[7:5], 1'b0};
         5'b10011, 5'b11000, 5'b10010:
            w_decoded = {1'b1, bus.inst_in[10:8], 1'b0};
         5'b0011?:
            w_decoded = {1'b1, 3'd7, 1'b1};        // JAL/JALR link to R7
         5'b0010?, 5'b011??:
            w_decoded = {1'b0, 3'd0, 1'b1};
         default:
            w_decoded = 5'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stageD    <= 5'b0;
         r_stageX    <= 5'b0;
         r_stageM    <= 5'b0;
         r_stageW    <= 5'b0;
         r_bubbleCnt <= 16'b0;
      end else if (bus.en) begin
         r_stageW <= r_stageM;
         r_stageM <= r_stageX;
         if (bus.flush) begin
            // Branch resolved in X: the X slot and the fetch slot are squashed
            r_stageX <= 5'b0;
            r_stageD <= 5'b0;
         end else begin
            r_stageX <= r_stageD;
            r_stageD <= w_decoded;
            if ((bus.inst_in == NOP) && (r_bubbleCnt != c_CNT_MAX)) begin
               r_bubbleCnt <= r_bubbleCnt + 16'd1;
            end
         end
      end
   end

   assign {bus.regWrtD, bus.wrtRegD, bus.branchInstD} = r_stageD;
   assign {bus.regWrtX, bus.wrtRegX, bus.branchInstX} = r_stageX;
   assign {bus.regWrtM, bus.wrtRegM, bus.branchInstM} = r_stageM;
   assign {bus.regWrtW, bus.wrtRegW, bus.branchInstW} = r_stageW;
   assign bus.bubble_cnt = r_bubbleCnt;

endmodule
`default_nettype wire
